// File: rtl/button_debouncer.sv
`timescale 1ns/1ps
// Debounces a raw asynchronous input. A SYNC_STAGES-deep synchroniser feeds a four-state
// qualification FSM, which commits a new level after DEBOUNCE_CYCLES consecutive samples.
module button_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_signal,
    output logic out_signal,
    output logic out_busy
);
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_t;

    localparam state_t               RESET_STATE = RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   out_q;
    logic                   out_d;

    // Plain shift chain: bit 0 is the only flop that ever sees the raw pin.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], in_signal};
    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            out_q   <= RESET_LEVEL;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // The counter defaults to zero, so every STABLE state and every rejection clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        out_d   = out_q;
        case (state_q)
            STABLE_LOW: begin
                if (sync_s) begin
                    state_d = PEND_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_HIGH: begin
                if (!sync_s) begin
                    state_d = STABLE_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    out_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_s) begin
                    state_d = PEND_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_LOW: begin
                if (sync_s) begin
                    state_d = STABLE_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    out_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    always_comb begin
        out_signal = out_q;
        out_busy   = (state_q == PEND_HIGH) || (state_q == PEND_LOW);
    end

endmodule

// File: tb/tb_button_debouncer.sv
`timescale 1ns/1ps
// Scoreboard bench for button_debouncer: each scenario queues the expected per-cycle
// out_signal/out_busy before driving the raw input, then pops and compares every cycle.
module tb_button_debouncer;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_WIDTH       = 16;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

    typedef struct {
        logic exp_out;
        logic exp_busy;
    } exp_t;

    exp_t sb_q[$];
    int   strobe_q[$];

    logic clk;
    logic rst;
    logic raw;
    logic out_signal;
    logic out_busy;
    int   vec_n  = 0;
    int   miss_n = 0;

    button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .in_clock  (clk),
        .in_reset  (rst),
        .in_signal (raw),
        .out_signal(out_signal),
        .out_busy  (out_busy)
    );

    // Rising edges at 5, 7, 9, ...; raw changes and checks happen on falling edges.
    initial begin
        clk = 1'b0;
        #4;
        forever #1 clk = ~clk;
    end

    task automatic test_reset();
        exp_t ex;
        rst = 1'b0;
        raw = 1'b1;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 6 + 12; i++) sb_q.push_back('{exp_out: 1'b0, exp_busy: 1'b0});
        ex = sb_q.pop_front();
        vec_n++;
        if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
            miss_n++;
            $display("FAIL reset_immediate: out=%b busy=%b, required out=%b busy=%b",
                     out_signal, out_busy, ex.exp_out, ex.exp_busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL reset_hold cyc=%0d: out=%b busy=%b, required out=%b busy=%b",
                         i, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
        raw = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL reset_release cyc=%0d: out=%b busy=%b, required out=%b busy=%b",
                         i, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
    endtask

    // Starts from a settled level of !lvl and steps the raw input to lvl.
    task automatic test_step(input logic lvl);
        exp_t ex;
        int   n_cyc = LAT + 4;
        for (int k = 1; k <= n_cyc; k++)
            sb_q.push_back('{exp_out:  (k >= LAT) ? lvl : ~lvl,
                             exp_busy: (k >= SYNC_STAGES + 1) && (k < LAT)});
        raw = lvl;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL step_to_%b k=%0d: out=%b busy=%b, required out=%b busy=%b",
                         lvl, k, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
    endtask

    // Raw high pulse of w clock periods from a settled low level.
    task automatic test_threshold(input int w);
        exp_t ex;
        int   n_cyc = w + LAT + 4;
        for (int k = 1; k <= n_cyc; k++) begin
            if (w < DEBOUNCE_CYCLES)
                sb_q.push_back('{exp_out:  1'b0,
                                 exp_busy: (k >= SYNC_STAGES + 1) && (k <= SYNC_STAGES + w)});
            else
                sb_q.push_back('{exp_out:  (k >= LAT) && (k <= w + LAT - 1),
                                 exp_busy: ((k >= SYNC_STAGES + 1) && (k <= LAT - 1)) ||
                                           ((k >= w + SYNC_STAGES + 1) && (k <= w + LAT - 1))});
        end
        for (int n = 0; n < n_cyc; n++) begin
            raw = (n < w);
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL threshold_w%0d k=%0d: out=%b busy=%b, required out=%b busy=%b",
                         w, n + 1, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
    endtask

    // Toggles every clock for 11 periods ending high; final change first sampled on edge 11.
    task automatic test_bounce();
        exp_t ex;
        int   n_cyc = 22;
        int   f_edge = 11;
        for (int k = 1; k <= n_cyc; k++)
            sb_q.push_back('{exp_out:  (k >= f_edge + LAT - 1),
                             exp_busy: ((k % 2 == 1) && (k >= 3) && (k <= f_edge)) ||
                                       ((k >= f_edge + SYNC_STAGES) && (k <= f_edge + LAT - 2))});
        for (int n = 0; n < n_cyc; n++) begin
            raw = (n <= 10) ? (n % 2 == 0) : 1'b1;
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL bounce k=%0d: out=%b busy=%b, required out=%b busy=%b",
                         n + 1, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
    endtask

    // Step 0->1, reset while qualifying (counter=2), then requalify after release.
    task automatic test_reset_mid();
        exp_t ex;
        for (int k = 1; k <= 4; k++) sb_q.push_back('{exp_out: 1'b0, exp_busy: (k >= 3)});
        for (int i = 0; i < 3; i++)  sb_q.push_back('{exp_out: 1'b0, exp_busy: 1'b0});
        for (int k = 1; k <= LAT + 3; k++)
            sb_q.push_back('{exp_out:  (k >= LAT),
                             exp_busy: (k >= SYNC_STAGES + 1) && (k < LAT)});
        raw = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL mid_pre k=%0d: out=%b busy=%b, required out=%b busy=%b",
                         k, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
        rst = 1'b1;
        #0.5;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL mid_reset i=%0d: out=%b busy=%b, required out=%b busy=%b",
                         i, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            ex = sb_q.pop_front();
            vec_n++;
            if (out_signal !== ex.exp_out || out_busy !== ex.exp_busy) begin
                miss_n++;
                $display("FAIL mid_post k=%0d: out=%b busy=%b, required out=%b busy=%b",
                         k, out_signal, out_busy, ex.exp_out, ex.exp_busy);
            end
        end
    endtask

    // Bouncing press then bouncing release through a rise/fall edge detector on out_signal.
    task automatic test_chain();
        logic press[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic release_[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic last;
        int   strobes = 0;
        int   got;
        int   want;
        strobe_q.push_back(5 + LAT);
        strobe_q.push_back(-(18 + 5 + LAT));
        last = out_signal;
        for (int n = 0; n < 36; n++) begin
            if (n < 6)       raw = press[n];
            else if (n < 18) raw = 1'b1;
            else if (n < 24) raw = release_[n - 18];
            else             raw = 1'b0;
            @(negedge clk);
            if (out_signal !== last) begin
                strobes++;
                got = out_signal ? (n + 1) : -(n + 1);
                vec_n++;
                if (strobe_q.size() == 0) begin
                    miss_n++;
                    $display("FAIL chain_strobe: strobe at %0d, required none", got);
                end else begin
                    want = strobe_q.pop_front();
                    if (got !== want) begin
                        miss_n++;
                        $display("FAIL chain_strobe: strobe at %0d, required %0d", got, want);
                    end
                end
            end
            last = out_signal;
        end
        vec_n++;
        if (strobes !== 2 || strobe_q.size() !== 0) begin
            miss_n++;
            $display("FAIL chain_count: strobes=%0d pending=%0d, required strobes=2 pending=0",
                     strobes, strobe_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_step(1'b1);
        test_step(1'b0);
        test_threshold(3);
        test_threshold(4);
        test_bounce();
        test_step(1'b0);
        test_reset_mid();
        test_step(1'b0);
        test_chain();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
